// File: rtl/aes_v2_pkg.sv
// aes_v2_pkg: shared definitions for the AES word unit.
//   - aes_op_e    : operation encodings carried on the op port
//   - aes_state_e : controller state encodings (also exported for debug)
//   - xtime / gf_mul / gf_inv : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
package aes_v2_pkg;

  typedef enum logic [1:0] {
    AES_OP_SUB    = 2'b00,
    AES_OP_MIX    = 2'b01,
    AES_OP_SUBMIX = 2'b10,
    AES_OP_ILL    = 2'b11
  } aes_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } aes_state_e;

  // Multiply by x (i.e. by 0x02) in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant operand this folds to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_v2_if.sv
// aes_v2_if: request/response bundle between the CPU AES datapath (master)
// and the aes_v2 unit (slave).
//   valid, op, dec, rs1 : master -> slave request
//   ready, rd, err      : slave -> master response
//
// Handshake: the master raises valid with op/dec/rs1 and holds all of them
// stable while valid && !ready. The slave answers with a single-cycle ready
// pulse; rd and err are meaningful only in that cycle (both are 0 otherwise).
// Dropping valid before ready abandons the request and no ready follows.
// valid still high in the cycle after ready starts a new request.
interface aes_v2_if;
  logic        valid;
  logic [1:0]  op;
  logic        dec;
  logic [31:0] rs1;
  logic        ready;
  logic [31:0] rd;
  logic        err;

  modport master (output valid, op, dec, rs1, input  ready, rd, err);
  modport slave  (input  valid, op, dec, rs1, output ready, rd, err);
endinterface

// File: rtl/aes_mix_word.sv
// aes_mix_word: combinational MixColumns / InvMixColumns on one 32-bit column.
//   col_in  : input column, byte i = col_in[8i+7:8i]
//   dec     : 0 = MixColumns, 1 = InvMixColumns
//   col_out : transformed column
// Written as a pure function of its inputs so it can also serve as a golden
// reference model.
module aes_mix_word
  import aes_v2_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        dec,
  output logic [31:0] col_out
);

  logic [3:0][7:0] b;
  logic [3:0][7:0] o;
  logic [7:0]      b0, b1, b2, b3;
  logic [7:0]      fwd, inv;

  assign b       = col_in;
  assign col_out = o;

  always_comb begin
    o   = '0;
    b0  = 8'h00;
    b1  = 8'h00;
    b2  = 8'h00;
    b3  = 8'h00;
    fwd = 8'h00;
    inv = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b0  = b[2'(i)];
      b1  = b[2'(i + 1)];
      b2  = b[2'(i + 2)];
      b3  = b[2'(i + 3)];
      fwd = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
      inv = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
      o[2'(i)] = dec ? inv : fwd;
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box / inverse S-box for one byte.
//   in_byte  : input byte
//   dec      : 0 = SubBytes, 1 = InvSubBytes
//   out_byte : substituted byte
// A single GF(2^8) inverter is shared by both directions; the affine
// transform is applied after it (forward) or its inverse before it (inverse).
// Tying dec to 0 lets synthesis strip the inverse path.
module aes_sbox
  import aes_v2_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       dec,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] rotl(input logic [7:0] b, input logic [2:0] n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 3'd1) ^ rotl(b, 3'd2) ^ rotl(b, 3'd3) ^ rotl(b, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 3'd1) ^ rotl(s, 3'd3) ^ rotl(s, 3'd6) ^ 8'h05;
  endfunction

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  assign inv_in   = dec ? inv_affine(in_byte) : in_byte;
  assign inv_out  = gf_inv(inv_in);
  assign out_byte = dec ? inv_out : affine(inv_out);

endmodule

// File: rtl/aes_v2.sv
// aes_v2: multi-cycle AES column unit for the CPU AES instruction datapath.
// Performs SubBytes, MixColumns or fused SubBytes+MixColumns (forward or
// inverse) on the 32-bit column in rs1.
//   g_clk     : clock
//   g_reset   : synchronous active-high reset
//   bus       : aes_v2_if slave (valid/op/dec/rs1 in, ready/rd/err out)
//   dbg_state : current controller state
// Parameters:
//   SBOX_LANES : S-boxes instantiated (1, 2 or 4); bytes substituted per cycle
//   DEC_EN     : 1 builds inverse support; 0 treats dec as 0
//
// Latency to the ready cycle (cycle 0 = valid first sampled in IDLE):
//   SUB = 4/SBOX_LANES, MIX = 1, SUBMIX = 4/SBOX_LANES + 1, illegal = 1.
// The first byte group and a standalone MIX are both resolved in the accept
// cycle itself; the MIX state is only the second phase of SUBMIX.
module aes_v2
  import aes_v2_pkg::*;
#(
  parameter int SBOX_LANES = 4,
  parameter bit DEC_EN     = 1'b1
) (
  input  logic       g_clk,
  input  logic       g_reset,
  aes_v2_if.slave    bus,
  output aes_state_e dbg_state
);

  localparam int         K        = 4 / SBOX_LANES;
  localparam logic [1:0] CNT_LAST = 2'(K - 1);

  aes_state_e      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][7:0] part_q, part_d;
  logic [31:0]     res_q, res_d;
  logic            err_q, err_d;

  aes_op_e         op_in;
  logic            dec_eff;
  logic [3:0][7:0] col_in;
  logic [1:0]      grp;
  logic            last_grp;
  logic            sub_active;
  logic [31:0]     mix_src;
  logic [31:0]     mix_out;

  logic [7:0]      lane_in  [SBOX_LANES];
  logic [7:0]      lane_out [SBOX_LANES];
  logic [1:0]      lane_idx [SBOX_LANES];

  assign op_in   = aes_op_e'(bus.op);
  assign dec_eff = DEC_EN && bus.dec;
  assign col_in  = bus.rs1;

  // The byte group being substituted: group 0 in the accept cycle, then cnt.
  assign grp      = (state_q == ST_SUB) ? cnt_q : 2'd0;
  assign last_grp = (grp == CNT_LAST);

  // Lanes only see real data while a substitution is in progress; otherwise
  // their inputs are held at 0 to limit switching and data-dependent leakage.
  assign sub_active = bus.valid &&
                      (((state_q == ST_IDLE) &&
                        ((op_in == AES_OP_SUB) || (op_in == AES_OP_SUBMIX))) ||
                       (state_q == ST_SUB));

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign lane_idx[j] = 2'(int'(grp) * SBOX_LANES + j);
    assign lane_in[j]  = sub_active ? col_in[lane_idx[j]] : 8'h00;

    aes_sbox u_sbox (
      .in_byte  (lane_in[j]),
      .dec      (dec_eff),
      .out_byte (lane_out[j])
    );
  end

  // Standalone MIX works on rs1; the SUBMIX second phase on the partials.
  assign mix_src = (state_q == ST_MIX) ? part_q : bus.rs1;

  aes_mix_word u_mix (
    .col_in  (mix_src),
    .dec     (dec_eff),
    .col_out (mix_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    res_d   = res_q;
    err_d   = err_q;

    if (sub_active) begin
      for (int j = 0; j < SBOX_LANES; j++) begin
        part_d[lane_idx[j]] = lane_out[j];
      end
    end

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        cnt_d = 2'd0;
        if (bus.valid) begin
          case (op_in)
            AES_OP_SUB, AES_OP_SUBMIX: begin
              if (!last_grp) begin
                cnt_d   = 2'd1;
                state_d = ST_SUB;
              end else if (op_in == AES_OP_SUB) begin
                res_d   = part_d;
                state_d = ST_DONE;
              end else begin
                state_d = ST_MIX;
              end
            end
            AES_OP_MIX: begin
              res_d   = mix_out;
              state_d = ST_DONE;
            end
            default: begin
              res_d   = 32'h0;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_SUB: begin
        if (!bus.valid) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
          part_d  = '0;
        end else if (last_grp) begin
          cnt_d = 2'd0;
          if (op_in == AES_OP_SUBMIX) begin
            state_d = ST_MIX;
          end else begin
            res_d   = part_d;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_MIX: begin
        cnt_d = 2'd0;
        if (!bus.valid) begin
          state_d = ST_IDLE;
          part_d  = '0;
        end else begin
          res_d   = mix_out;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Always return through IDLE so ready pulses are never adjacent.
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        part_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        part_d  = '0;
        res_d   = 32'h0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      part_q  <= '0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready = (state_q == ST_DONE);
  assign bus.rd    = bus.ready ? res_q : 32'h0;
  assign bus.err   = bus.ready && err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/aes_v2.md
Name: aes_v2

Overview:
- Parametrised successor to the single-cycle AES word unit; serves the CPU's AES instruction datapath.
- Performs SubBytes, MixColumns, or fused SubBytes+MixColumns, forward or inverse, on one 32-bit column held in rs1.
- SBox lane count is configurable, trading area for latency.
- Uses a valid/ready handshake; an illegal-op error flag is added.

Parameters:
- SBOX_LANES, 4, SBoxes instantiated; legal values are 1, 2 and 4; the unit processes SBOX_LANES bytes per cycle.
- DEC_EN, 1, inverse-operation support; when 0, dec is ignored (treated as 0) and no inverse logic is built.

Ports:
- g_clk  in  1  clock.
- g_reset  in  1  synchronous, active-high reset.
- valid  in  1  request; rs1/op/dec held stable by the issuer while valid && !ready.
- op  in  2  00 SUB, 01 MIX, 10 SUBMIX, 11 illegal.
- dec  in  1  0 forward, 1 inverse.
- rs1  in  32  input column; byte i = rs1[8i+7:8i].
- ready  out  1  one-cycle pulse; rd and err are valid in that cycle.
- rd  out  32  result; forced to 0 whenever ready=0.
- err  out  1  high with ready for op=11; otherwise 0.

Behaviour:
- Reset: state=IDLE, byte counter=0, result and partial registers cleared, ready=0, rd=0, err=0. Reset mid-operation discards all work; no ready follows.
- States: IDLE, SUB, MIX, DONE. K=4/SBOX_LANES. Cycle 0 is the cycle valid is first sampled high in IDLE.
- IDLE:
  - op=00 or 10 -> SUB; cycle 0 processes bytes 0..SBOX_LANES-1.
  - op=01 -> MIX.
  - op=11 -> DONE with err pending.
- SUB:
  - Each cycle, SBox/inverse-SBox lane j writes partial byte (cnt*SBOX_LANES+j); cnt increments.
  - After the K-th byte group: op=00 -> DONE; op=10 -> MIX.
- MIX:
  - Forward: out_i = 2*b_i ^ 3*b_(i+1) ^ b_(i+2) ^ b_(i+3), indices mod 4, GF(2^8) modulo 0x11b.
  - Inverse: out_i = 0e*b_i ^ 0b*b_(i+1) ^ 0d*b_(i+2) ^ 09*b_(i+3).
  - Source is rs1 for op=01, the partial register for op=10. Result is registered, then -> DONE.
- DONE: ready=1 for exactly one cycle, rd=result (0 if err), then -> IDLE.
  - If valid is still high in the cycle after DONE, it is a new request accepted in IDLE.
  - There are no back-to-back ready pulses without an IDLE cycle.
- Latency (ready cycle): SUB = K; MIX = 1; SUBMIX = K+1; illegal = 1.
  - SBOX_LANES=4: SUB 1, SUBMIX 2.
  - SBOX_LANES=1: SUB 4, SUBMIX 5.
- Abort: if valid drops in SUB or MIX, the next state is IDLE, partials are cleared and no ready is produced. The issuer must not change inputs while valid stays high; behaviour under input change is undefined.
- Only SBox inputs of active lanes are gated by valid; idle lanes see 0, matching the existing power/leakage gating policy.
- DEC_EN=0: dec is forced to 0 internally; op semantics are unchanged.
- SUBMIX inverse order: InvSubBytes, then InvMixColumns, on the same column.

Decomposition:
- Package aes_v2_pkg holds:
  - op encodings (AES_OP_SUB, AES_OP_MIX, AES_OP_SUBMIX);
  - state encodings;
  - GF(2^8) xtime and constant-multiply functions.
- Sub-module aes_mix_word: combinational 32-bit forward/inverse MixColumns with a dec input; reusable by the formal golden model.
- Existing aes_sbox is instantiated SBOX_LANES times.

Test Plan:
- SUB forward: SBOX_LANES=4, rs1=0x00010053, dec=0 -> ready at cycle 1, rd=0x637C63ED, err=0. With SBOX_LANES=1: same rd, ready at cycle 4.
- MIX forward, then inverse:
  - rs1=0x455313DB, dec=0 -> rd=0xBCA14D8E at cycle 1.
  - rs1=0xBCA14D8E, dec=1 -> rd=0x455313DB.
- SUBMIX: rs1=0x00000000, dec=0 -> rd=0x63636363.
  - SBOX_LANES=2: ready at cycle 3.
  - Inverse SUB on 0x63636363 -> 0x00000000.
- Illegal op=11 -> ready at cycle 1, err=1, rd=0. The next request is accepted normally.
- Abort and reset: SBOX_LANES=1, SUB started and valid dropped at cycle 2 -> no ready; a new SUB then completes correctly. Repeat with g_reset at cycle 2 -> no ready, outputs 0.
- Back-to-back with valid held high across two SUB ops (SBOX_LANES=4) -> ready at cycles 1 and 3, with one IDLE cycle between.
- Random formal check against aes_mix_word/aes_sbox models for every SBOX_LANES value.
